mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Single-outstanding memory access controller that sits between
//               a CPU-side request strobe and a synchronous RAM. Each accepted
//               request latches address (MAR), write data (MDR) and direction,
//               issues one RAM strobe, waits one cycle for registered read
//               data, then pulses done. The latency is the same for reads and
//               writes: req sampled at E0, strobe between E0 and E1, done and
//               valid rdata between E2 and E3.
//
// Ports       : clk       - clock, all state changes on the rising edge
//               clr       - synchronous active-high reset
//               req       - access request strobe (sampled in IDLE/DONE only)
//               we        - 1 = write, 0 = read (sampled with req)
//               addr      - word address (sampled with req)
//               wdata     - write data (sampled with req)
//               busy      - access in flight (ISSUE/WAIT/DONE)
//               done      - one-cycle completion pulse
//               rdata     - data of the last completed read
//               ram_read  - RAM read strobe
//               ram_write - RAM write strobe
//               ram_addr  - RAM address (MAR)
//               ram_din   - RAM write data (MDR)
//               ram_dout  - RAM read data, valid one edge after ram_read
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int BITS    = 32,
    parameter int RAMSIZE = 512,
    parameter int ADDR    = $clog2(RAMSIZE)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req,
    input  logic            we,
    input  logic [ADDR-1:0] addr,
    input  logic [BITS-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] rdata,
    output logic            ram_read,
    output logic            ram_write,
    output logic [ADDR-1:0] ram_addr,
    output logic [BITS-1:0] ram_din,
    input  logic [BITS-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            r_op;      // latched direction: 1 = write
    logic [ADDR-1:0] r_mar;
    logic [BITS-1:0] r_mdr;
    logic [BITS-1:0] r_rdata;

    // ------------------------------------------------------------------
    // Next-state logic. A request is only looked at in IDLE and DONE;
    // accepting in DONE lets back-to-back accesses skip the IDLE cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = S_DONE;
            S_DONE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers. MAR/MDR only change on an accepted
    // request so the RAM sees a stable address/data until the next one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_op    <= 1'b0;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mar <= addr;
                r_mdr <= wdata;
                r_op  <= we;
            end
            // RAM output is registered: the strobe edge (E1) loads it,
            // so it is sampled at the edge that closes WAIT (E2).
            if ((r_state == S_WAIT) && !r_op) begin
                r_rdata <= ram_dout;
            end
        end
    end

    // Outputs are either registers or decoded from the state register
    // (plus the registered op flag), so they are glitch-free.
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign ram_read  = (r_state == S_ISSUE) && !r_op;
    assign ram_write = (r_state == S_ISSUE) &&  r_op;
    assign ram_addr  = r_mar;
    assign ram_din   = r_mdr;
    assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a behavioural
//               synchronous RAM (registered read data). Table-driven single
//               accesses plus hand-written sequences for back-to-back
//               requests, ignored requests and reset in mid-access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int C_BITS    = 32;
    localparam int C_RAMSIZE = 512;
    localparam int C_ADDR    = $clog2(C_RAMSIZE);

    logic              clk = 1'b0;
    logic              clr;
    logic              req;
    logic              we;
    logic [C_ADDR-1:0] addr;
    logic [C_BITS-1:0] wdata;
    logic              busy;
    logic              done;
    logic [C_BITS-1:0] rdata;
    logic              ram_read;
    logic              ram_write;
    logic [C_ADDR-1:0] ram_addr;
    logic [C_BITS-1:0] ram_din;
    logic [C_BITS-1:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .BITS    (C_BITS),
        .RAMSIZE (C_RAMSIZE)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioural RAM: registered read data, valid one edge after ram_read.
    logic [C_BITS-1:0] mem [C_RAMSIZE];
    initial begin
        for (int i = 0; i < C_RAMSIZE; i++) mem[i] = '0;
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_00A1;
        mem[2] = 32'h0000_00B2;
        mem[4] = 32'h0080_0055;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        if (ram_read)  ram_dout      <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobes must never overlap, checked every cycle away from the edge.
    always @(negedge clk) begin
        if (ram_read === 1'b1 || ram_write === 1'b1)
            chk("strobe_exclusive", {31'd0, ram_read & ram_write}, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated access starting from IDLE with full latency checks.
    task automatic access(input string nm, input logic w, input logic [C_ADDR-1:0] a,
                          input logic [C_BITS-1:0] wd, input logic [C_BITS-1:0] exp_rd);
        req = 1'b1; we = w; addr = a; wdata = wd;
        step();                                   // past E0: ISSUE
        req = 1'b0;
        chk({nm, "_e0_busy"},  32'(busy), 32'd1);
        chk({nm, "_e0_done"},  32'(done), 32'd0);
        chk({nm, "_e0_write"}, 32'(ram_write), 32'(w));
        chk({nm, "_e0_read"},  32'(ram_read), 32'(!w));
        chk({nm, "_e0_addr"},  32'(ram_addr), 32'(a));
        chk({nm, "_e0_din"},   ram_din, wd);
        step();                                   // past E1: WAIT
        chk({nm, "_e1_strb"},  32'({ram_read, ram_write}), 32'd0);
        chk({nm, "_e1_busy"},  32'(busy), 32'd1);
        chk({nm, "_e1_done"},  32'(done), 32'd0);
        step();                                   // past E2: DONE
        chk({nm, "_e2_done"},  32'(done), 32'd1);
        chk({nm, "_e2_busy"},  32'(busy), 32'd1);
        chk({nm, "_e2_rdata"}, rdata, exp_rd);
        step();                                   // past E3: IDLE
        chk({nm, "_e3_done"},  32'(done), 32'd0);
        chk({nm, "_e3_busy"},  32'(busy), 32'd0);
        chk({nm, "_e3_rdata"}, rdata, exp_rd);
    endtask

    typedef struct {
        logic              w;
        logic [C_ADDR-1:0] a;
        logic [C_BITS-1:0] wd;
        logic [C_BITS-1:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Expected rdata after each access, hand-computed from preload and
        // prior writes; a write leaves rdata at the previous read's value.
        vecs.push_back('{1'b1, 9'd5,   32'hDEAD_BEEF, 32'h0000_0000});
        vecs.push_back('{1'b0, 9'd5,   32'h1234_5678, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 9'd4,   32'h0000_0000, 32'h0080_0055});
        vecs.push_back('{1'b0, 9'd0,   32'h0000_0000, 32'h0000_0011});
        vecs.push_back('{1'b1, 9'd0,   32'h0000_0022, 32'h0000_0011});
        vecs.push_back('{1'b0, 9'd0,   32'hAAAA_5555, 32'h0000_0022});
        vecs.push_back('{1'b1, 9'd511, 32'hFFFF_FFFF, 32'h0000_0022});
        vecs.push_back('{1'b0, 9'd511, 32'h0000_0000, 32'hFFFF_FFFF});

        clr = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        step(); step();
        clr = 1'b0;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_strb",  32'({ram_read, ram_write}), 32'd0);
        chk("rst_addr",  32'(ram_addr), 32'd0);
        chk("rst_din",   ram_din, 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        foreach (vecs[i])
            access($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].exp_rd);

        // Back-to-back reads: req held high, second address presented while
        // the first access is in flight (ignored until DONE).
        req = 1'b1; we = 1'b0; addr = 9'd1; wdata = '0;
        step();                                   // E0: ISSUE addr 1
        addr = 9'd2;
        chk("b2b_rd1", 32'(ram_read), 32'd1);
        chk("b2b_a1",  32'(ram_addr), 32'd1);
        step();                                   // E1: WAIT
        chk("b2b_wait_a1", 32'(ram_addr), 32'd1);
        step();                                   // E2: DONE
        chk("b2b_done1",  32'(done), 32'd1);
        chk("b2b_rdata1", rdata, 32'h0000_00A1);
        step();                                   // E3: ISSUE addr 2, no IDLE
        req = 1'b0;
        chk("b2b_nodone", 32'(done), 32'd0);
        chk("b2b_busy",   32'(busy), 32'd1);
        chk("b2b_rd2",    32'(ram_read), 32'd1);
        chk("b2b_a2",     32'(ram_addr), 32'd2);
        step();                                   // E4: WAIT
        chk("b2b_e4_done", 32'(done), 32'd0);
        step();                                   // E5: DONE (3 after first)
        chk("b2b_done2",  32'(done), 32'd1);
        chk("b2b_rdata2", rdata, 32'h0000_00B2);
        step();
        chk("b2b_idle", 32'(busy), 32'd0);

        // Requests pulsed during ISSUE and WAIT are ignored.
        req = 1'b1; we = 1'b1; addr = 9'd7; wdata = 32'h0000_0077;
        step();                                   // E0: ISSUE (write 7)
        we = 1'b0; addr = 9'd9; wdata = 32'h0000_0099;   // req still high in ISSUE
        chk("ign_wr", 32'(ram_write), 32'd1);
        step();                                   // E1: WAIT, request ignored
        chk("ign_wait_strb", 32'({ram_read, ram_write}), 32'd0);
        chk("ign_wait_addr", 32'(ram_addr), 32'd7);
        step();                                   // E2: DONE, request ignored
        req = 1'b0;
        chk("ign_done",      32'(done), 32'd1);
        chk("ign_done_addr", 32'(ram_addr), 32'd7);
        chk("ign_done_din",  ram_din, 32'h0000_0077);
        step();                                   // E3: IDLE
        chk("ign_idle_busy", 32'(busy), 32'd0);
        chk("ign_idle_strb", 32'({ram_read, ram_write}), 32'd0);
        step();
        chk("ign_no_done", 32'(done), 32'd0);
        access("ign_rb", 1'b0, 9'd7, 32'd0, 32'h0000_0077);

        // Reset while a read strobe is on.
        req = 1'b1; we = 1'b0; addr = 9'd4; wdata = 32'h5A5A_5A5A;
        step();
        req = 1'b0;
        chk("clr_pre_rd", 32'(ram_read), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy",  32'(busy), 32'd0);
        chk("clr_done",  32'(done), 32'd0);
        chk("clr_strb",  32'({ram_read, ram_write}), 32'd0);
        chk("clr_addr",  32'(ram_addr), 32'd0);
        chk("clr_din",   ram_din, 32'd0);
        chk("clr_rdata", rdata, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("clr_idle_done%0d", k), 32'(done), 32'd0);
            chk($sformatf("clr_idle_busy%0d", k), 32'(busy), 32'd0);
        end

        // clr wins over req at the same edge.
        req = 1'b1; clr = 1'b1; addr = 9'd3;
        step();
        req = 1'b0; clr = 1'b0;
        chk("prio_busy", 32'(busy), 32'd0);
        chk("prio_strb", 32'({ram_read, ram_write}), 32'd0);
        chk("prio_addr", 32'(ram_addr), 32'd0);

        // Normal operation resumes after reset.
        access("post_clr", 1'b0, 9'd4, 32'd0, 32'h0080_0055);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
